// File: rtl/dotproduct_seq_if.sv
// Operand/result handshake bundle for the sequential signed-weight dot product.
// The master side supplies operand sets and accepts results; the slave side is the datapath.
interface dotproduct_seq_if #(
   parameter int N_ELEM = 10,
   parameter int ELEM_W = 4,
   parameter int ACC_W  = 12
);
   logic                       in_valid;
   logic                       in_ready;
   logic [N_ELEM*ELEM_W-1:0]   vec_a;
   logic [N_ELEM*ELEM_W-1:0]   vec_b;
   logic [N_ELEM-1:0]          vec_c;
   logic [N_ELEM-1:0]          vec_d;
   logic                       out_valid;
   logic                       out_ready;
   logic signed [ACC_W-1:0]    result;
   logic                       sat;

   modport master (
      output in_valid, vec_a, vec_b, vec_c, vec_d, out_ready,
      input  in_ready, out_valid, result, sat
   );

   modport slave (
      input  in_valid, vec_a, vec_b, vec_c, vec_d, out_ready,
      output in_ready, out_valid, result, sat
   );
endinterface

// File: rtl/dotproduct_seq.sv
// Multi-cycle signed-weight dot product: result = sum s_i*A[i]*B[i], s_i = +1 when C[i]==D[i],
// -1 otherwise. LANES elements are folded into a wide accumulator per BUSY cycle, and the final
// sum is clamped to the ACC_W-bit signed output range with a saturation flag.
module dotproduct_seq #(
   parameter int N_ELEM      = 10,
   parameter int ELEM_W      = 4,
   parameter int LANES       = 2,
   parameter int ACC_W       = 12,
   parameter bit SIGNED_ELEM = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   dotproduct_seq_if.slave  bus
);

   // Operands are padded up to a whole number of lane groups; padding elements are zero and
   // therefore contribute nothing, which removes any per-lane range test from the datapath.
   localparam int STEPS = (N_ELEM + LANES - 1) / LANES;
   localparam int PAD_N = STEPS * LANES;
   localparam int VEC_W = PAD_N * ELEM_W;
   localparam int INT_W = 2 * ELEM_W + $clog2(N_ELEM) + 2;
   localparam int IDX_W = $clog2(PAD_N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [VEC_W-1:0]         vecA_q, vecB_q;
   logic [PAD_N-1:0]         neg_q;
   logic signed [INT_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [ACC_W-1:0]  result_q, result_d;
   logic                     sat_q, sat_d;
   logic                     loadOps, shiftOps;
   logic signed [INT_W-1:0]  laneSum;
   logic signed [INT_W-1:0]  accNext;
   logic signed [ACC_W-1:0]  clampVal;
   logic                     clampSat;
   logic                     lastStep;

   // Widen one element to the internal signed width, honouring element signedness.
   function automatic logic signed [INT_W-1:0] extendElem(input logic [ELEM_W-1:0] e);
      if (SIGNED_ELEM)
         return {{(INT_W-ELEM_W){e[ELEM_W-1]}}, e};
      else
         return {{(INT_W-ELEM_W){1'b0}}, e};
   endfunction

   // Sum of the signed-weighted products for the lane group sitting at the bottom of the operand shifters.
   always_comb begin
      logic signed [INT_W-1:0] term;
      term    = '0;
      laneSum = '0;
      for (int l = 0; l < LANES; l++) begin
         term = extendElem(vecA_q[l*ELEM_W +: ELEM_W]) * extendElem(vecB_q[l*ELEM_W +: ELEM_W]);
         if (neg_q[l])
            term = -term;
         laneSum = laneSum + term;
      end
   end

   assign accNext  = acc_q + laneSum;
   assign lastStep = (int'(idx_q) + LANES) >= N_ELEM;

   // Clamp the final wide sum into the output range; a wide enough output just sign-extends.
   generate
      if (ACC_W >= INT_W) begin : gNoClamp
         assign clampVal = ACC_W'(accNext);
         assign clampSat = 1'b0;
      end else begin : gClamp
         logic [INT_W-ACC_W:0] upperBits;
         logic                 fits;
         assign upperBits = accNext[INT_W-1:ACC_W-1];
         assign fits      = (&upperBits) || !(|upperBits);
         assign clampSat  = !fits;
         assign clampVal  = fits ? accNext[ACC_W-1:0]
                          : (accNext[INT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}});
      end
   endgenerate

   // Next-state and datapath control for the IDLE -> BUSY -> DONE sequence.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      sat_d    = sat_q;
      loadOps  = 1'b0;
      shiftOps = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               loadOps = 1'b1;
               acc_d   = '0;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            shiftOps = 1'b1;
            acc_d    = accNext;
            idx_d    = IDX_W'(int'(idx_q) + LANES);
            if (lastStep) begin
               result_d = clampVal;
               sat_d    = clampSat;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, accumulator, index and result registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         sat_q    <= sat_d;
      end
   end

   // Operand shifters: capture on accept, then move the next lane group down each BUSY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vecA_q <= '0;
         vecB_q <= '0;
         neg_q  <= '0;
      end else if (loadOps) begin
         vecA_q <= VEC_W'(bus.vec_a);
         vecB_q <= VEC_W'(bus.vec_b);
         neg_q  <= PAD_N'(bus.vec_c ^ bus.vec_d);
      end else if (shiftOps) begin
         vecA_q <= vecA_q >> (LANES * ELEM_W);
         vecB_q <= vecB_q >> (LANES * ELEM_W);
         neg_q  <= neg_q >> LANES;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.sat       = sat_q;

endmodule

// File: tb/tb_dotproduct_seq.sv
// Directed bench for dotproduct_seq: default build, a 4-lane build and a signed-element build
// share one clock and reset, each driven through its own interface instance.
module tb_dotproduct_seq;

   logic clk;
   logic rst_n;
   int   compareCount;
   int   mismatchCount;

   localparam logic [39:0] ALL_F  = 40'hFFFF_FFFF_FF;
   localparam logic [39:0] ALL_3  = 40'h3333_3333_33;
   localparam logic [39:0] ALL_2  = 40'h2222_2222_22;
   localparam logic [39:0] ALL_1  = 40'h1111_1111_11;
   localparam logic [39:0] ELEM0F = 40'h0000_0000_0F;
   localparam logic [39:0] ELEM08 = 40'h0000_0000_08;
   localparam logic [39:0] ELEM07 = 40'h0000_0000_07;

   dotproduct_seq_if #(.N_ELEM(10), .ELEM_W(4), .ACC_W(12)) ifc0 ();
   dotproduct_seq_if #(.N_ELEM(10), .ELEM_W(4), .ACC_W(12)) ifc1 ();
   dotproduct_seq_if #(.N_ELEM(10), .ELEM_W(4), .ACC_W(12)) ifc2 ();

   dotproduct_seq #(.N_ELEM(10), .ELEM_W(4), .LANES(2), .ACC_W(12), .SIGNED_ELEM(1'b0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
   dotproduct_seq #(.N_ELEM(10), .ELEM_W(4), .LANES(4), .ACC_W(12), .SIGNED_ELEM(1'b0))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
   dotproduct_seq #(.N_ELEM(10), .ELEM_W(4), .LANES(2), .ACC_W(12), .SIGNED_ELEM(1'b1))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2.slave));

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int getOv(input int sel);
      case (sel)
         0: return int'(ifc0.out_valid);
         1: return int'(ifc1.out_valid);
         default: return int'(ifc2.out_valid);
      endcase
   endfunction

   function automatic int getIr(input int sel);
      case (sel)
         0: return int'(ifc0.in_ready);
         1: return int'(ifc1.in_ready);
         default: return int'(ifc2.in_ready);
      endcase
   endfunction

   function automatic int getRes(input int sel);
      case (sel)
         0: return int'(ifc0.result);
         1: return int'(ifc1.result);
         default: return int'(ifc2.result);
      endcase
   endfunction

   function automatic int getSat(input int sel);
      case (sel)
         0: return int'(ifc0.sat);
         1: return int'(ifc1.sat);
         default: return int'(ifc2.sat);
      endcase
   endfunction

   task automatic setInputs(input int sel, input logic [39:0] a, input logic [39:0] b,
                            input logic [9:0] c, input logic [9:0] d, input logic v);
      case (sel)
         0: begin ifc0.vec_a = a; ifc0.vec_b = b; ifc0.vec_c = c; ifc0.vec_d = d; ifc0.in_valid = v; end
         1: begin ifc1.vec_a = a; ifc1.vec_b = b; ifc1.vec_c = c; ifc1.vec_d = d; ifc1.in_valid = v; end
         default: begin ifc2.vec_a = a; ifc2.vec_b = b; ifc2.vec_c = c; ifc2.vec_d = d; ifc2.in_valid = v; end
      endcase
   endtask

   // Present one operand set, scramble the operands after capture, then wait (bounded) for
   // out_valid and check latency, result and saturation flag
   task automatic applyStimulus(input int sel, input logic [39:0] a, input logic [39:0] b,
                                input logic [9:0] c, input logic [9:0] d,
                                input int expRes, input int expSat, input int expLat,
                                input string tag);
      int cycles;
      setInputs(sel, a, b, c, d, 1'b1);
      @(posedge clk);
      #1;
      setInputs(sel, ALL_F, ALL_F, 10'h155, 10'h2AA, 1'b0);
      cycles = 0;
      while (getOv(sel) == 0 && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput({tag, ".latency"}, cycles, expLat);
      checkOutput({tag, ".result"}, getRes(sel), expRes);
      checkOutput({tag, ".sat"}, getSat(sel), expSat);
      checkOutput({tag, ".in_ready_busy"}, getIr(sel), 0);
   endtask

   // Consume the result (out_ready assumed high) and confirm return to IDLE
   task automatic finishOp(input int sel, input string tag);
      @(posedge clk);
      #1;
      checkOutput({tag, ".ov_cleared"}, getOv(sel), 0);
      checkOutput({tag, ".in_ready_back"}, getIr(sel), 1);
   endtask

   // Directed test sequence
   initial begin
      int seenOv;
      compareCount  = 0;
      mismatchCount = 0;
      rst_n = 1'b0;
      for (int s = 0; s < 3; s++) setInputs(s, '0, '0, '0, '0, 1'b0);
      ifc0.out_ready = 1'b1;
      ifc1.out_ready = 1'b1;
      ifc2.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;

      // Reset state
      checkOutput("reset.in_ready", getIr(0), 1);
      checkOutput("reset.out_valid", getOv(0), 0);
      checkOutput("reset.result", getRes(0), 0);
      checkOutput("reset.sat", getSat(0), 0);
      @(posedge clk);
      #1;

      // Positive saturation: 10*225 = 2250 clamps to 2047
      applyStimulus(0, ALL_F, ALL_F, 10'h000, 10'h000, 2047, 1, 5, "t1");
      finishOp(0, "t1");

      // Negative saturation, then a single negated term in range
      applyStimulus(0, ALL_F, ALL_F, 10'h000, 10'h3FF, -2048, 1, 5, "t2a");
      finishOp(0, "t2a");
      applyStimulus(0, ELEM0F, ELEM0F, 10'h001, 10'h000, -225, 0, 5, "t2b");
      finishOp(0, "t2b");

      // Cancelling halves, then back-to-back all-ones with C==D
      applyStimulus(0, ALL_3, ALL_2, 10'h000, 10'h3E0, 0, 0, 5, "t3a");
      finishOp(0, "t3a");
      applyStimulus(0, ALL_1, ALL_1, 10'h2B4, 10'h2B4, 10, 0, 5, "t3b");
      finishOp(0, "t3b");

      // Backpressure in DONE with in_valid asserted and different operands presented
      ifc0.out_ready = 1'b0;
      applyStimulus(0, ELEM0F, ELEM0F, 10'h001, 10'h000, -225, 0, 5, "t4");
      setInputs(0, ALL_F, ALL_F, 10'h000, 10'h000, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("t4.hold_ov", getOv(0), 1);
         checkOutput("t4.hold_result", getRes(0), -225);
         checkOutput("t4.hold_in_ready", getIr(0), 0);
      end
      ifc0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      setInputs(0, '0, '0, '0, '0, 1'b0);
      checkOutput("t4.release_ov", getOv(0), 0);
      checkOutput("t4.release_in_ready", getIr(0), 1);
      checkOutput("t4.result_held", getRes(0), -225);

      // Four lanes: three BUSY cycles, same values as the cancelling/all-ones pair
      applyStimulus(1, ALL_3, ALL_2, 10'h000, 10'h3E0, 0, 0, 3, "t5a");
      finishOp(1, "t5a");
      applyStimulus(1, ALL_1, ALL_1, 10'h000, 10'h000, 10, 0, 3, "t5b");
      finishOp(1, "t5b");

      // Signed elements: -8 * 7 with C==D
      applyStimulus(2, ELEM08, ELEM07, 10'h3FF, 10'h3FF, -56, 0, 5, "t5s");
      finishOp(2, "t5s");

      // Reset two cycles into BUSY discards the operation
      setInputs(0, ALL_F, ALL_F, 10'h000, 10'h000, 1'b1);
      @(posedge clk);
      #1;
      setInputs(0, '0, '0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t6.rst_out_valid", getOv(0), 0);
      checkOutput("t6.rst_in_ready", getIr(0), 1);
      checkOutput("t6.rst_result", getRes(0), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seenOv = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (getOv(0) != 0) seenOv = 1;
      end
      checkOutput("t6.no_stale_ov", seenOv, 0);
      checkOutput("t6.result_after", getRes(0), 0);
      applyStimulus(0, ALL_3, ALL_2, 10'h000, 10'h3E0, 0, 0, 5, "t6a");
      finishOp(0, "t6a");
      applyStimulus(0, ALL_1, ALL_1, 10'h000, 10'h000, 10, 0, 5, "t6b");
      finishOp(0, "t6b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
